flush_redirect_ctrl: RTL

//   Sequences the pipeline flush after write-back raises an exception or ERTN.
//   It latches the target PC (EENTRY for exceptions, ERA for ERTN), pulses a flush
//   to all stages, and holds a redirect request to fetch until fetch accepts it.
//   It then blocks commit for a programmable drain window and keeps saturating event counters.

---
 rtl/flush_redirect_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer: on a WB exception or ERTN, pulses a pipeline flush, holds a
// redirect to fetch until accepted, then blocks commit for a drain window.
module flush_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             excp_flush,
  input  logic             ertn_flush,
  input  logic [31:0]      eentry,
  input  logic [31:0]      era,
  input  logic             has_int,
  input  logic             redirect_ready,
  output logic             flush_all,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             commit_block,
  output logic             int_pending,
  output logic             busy,
  output logic [CNT_W-1:0] excp_cnt,
  output logic [CNT_W-1:0] ertn_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT, S_DRAIN} state_t;

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_drain;
  logic [31:0]       r_pc;
  logic [CNT_W-1:0]  r_excp_cnt;
  logic [CNT_W-1:0]  r_ertn_cnt;
  logic              r_int;
  logic              w_idle;
  logic              w_take_excp;
  logic              w_take_ertn;
  logic              w_accept;

  // Redirect handshake: redirect_valid stays high with a stable redirect_pc until the
  // first rising edge at which redirect_ready is also high; that edge is the transfer.
  assign w_idle      = (r_state == S_IDLE);
  assign w_take_excp = w_idle & excp_flush;
  assign w_take_ertn = w_idle & ertn_flush & ~excp_flush;
  assign w_accept    = (r_state == S_REDIRECT) & redirect_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (excp_flush | ertn_flush) w_next = S_FLUSH;
      S_FLUSH:    w_next = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) w_next = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
      S_DRAIN:    if (r_drain == '0) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Target PC and drain counter; events arriving while busy are wrong-path and dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= '0;
      r_drain <= '0;
    end else begin
      if (w_take_excp) begin
        r_pc <= eentry;
      end else if (w_take_ertn) begin
        r_pc <= era;
      end
      if (w_accept) begin
        r_drain <= DRAIN_LOAD;
      end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - DW'(1);
      end
    end
  end

  // Saturating event counters and sticky interrupt flag (exception clear beats set).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_excp_cnt <= '0;
      r_ertn_cnt <= '0;
      r_int      <= 1'b0;
    end else begin
      if (w_take_excp && (r_excp_cnt != '1)) r_excp_cnt <= r_excp_cnt + CNT_W'(1);
      if (w_take_ertn && (r_ertn_cnt != '1)) r_ertn_cnt <= r_ertn_cnt + CNT_W'(1);
      if (w_take_excp) begin
        r_int <= 1'b0;
      end else if (w_idle && has_int) begin
        r_int <= 1'b1;
      end
    end
  end

  assign flush_all      = (r_state == S_FLUSH);
  assign redirect_valid = (r_state == S_REDIRECT);
  assign commit_block   = (r_state != S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign redirect_pc    = r_pc;
  assign int_pending    = r_int;
  assign excp_cnt       = r_excp_cnt;
  assign ertn_cnt       = r_ertn_cnt;
  assign dbg_state      = r_state;

endmodule
